div_4bits: RTL and testbench
============================

DIV_4BITS -- requirements
Module: div_4bits

Interface
REQ-001 Parameter: bits, default 4, operand width; dividend is 2*bits wide, divisor is bits wide.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  request to divide; sampled only in IDLE.
REQ-005 A  input  2*bits  dividend; unsigned; captured on the accepting edge.
REQ-006 B  input  bits  divisor; unsigned; captured on the accepting edge.
REQ-007 busy_o  output  1  high while iterating (RUN).
REQ-008 done_o  output  1  one-cycle pulse; results valid and new.
REQ-009 Quotient_o  output  2*bits  unsigned quotient, floor(A/B).
REQ-010 Remainder_o  output  bits  unsigned remainder, A mod B.
REQ-011 dz_o  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-012 The FSM SHALL have three states, IDLE, RUN and DONE: IDLE->RUN on start_i=1; RUN->DONE after the last iteration; DONE->IDLE unconditionally.
REQ-013 The edge accepting start_i in IDLE is edge 0; A and B SHALL be latched at edge 0, and later input changes SHALL NOT affect the result.
REQ-014 Restoring shift-subtract: one quotient bit per edge, MSB first, on edges 1..2*bits; partial remainder register bits+1 wide.
REQ-015 State SHALL be DONE after edge 2*bits; done_o=1 for exactly that cycle; Quotient_o/Remainder_o updated at edge 2*bits.
REQ-016 busy_o SHALL be 1 exactly in RUN (2*bits cycles); done_o and busy_o SHALL never be 1 together.
REQ-017 Quotient_o, Remainder_o and dz_o SHALL hold their last values until the next completion; no intermediate values on outputs.
REQ-018 start_i during RUN or DONE SHALL be ignored (not queued); back-to-back operation needs start_i in the IDLE cycle after DONE.
REQ-019 Minimum start-to-start period SHALL be 2*bits+2 cycles.
REQ-020 Results SHALL satisfy A = Quotient_o*B + Remainder_o, Remainder_o < B, for all B != 0.

Reset
REQ-021 rst=1 at an edge SHALL force IDLE and clear busy_o, done_o, Quotient_o, Remainder_o, dz_o and all internal registers to 0.
REQ-022 Reset during RUN or DONE SHALL abort the operation with no done_o pulse; rst has priority over start_i.

Configuration
REQ-023 Macro DIV0_DETECT_EN defined: B=0 at edge 0 SHALL skip RUN (IDLE->DONE, done_o one cycle after edge 0), with Quotient_o all ones, Remainder_o=0, dz_o=1; dz_o=0 for B!=0.
REQ-024 DIV0_DETECT_EN undefined: B=0 SHALL run the full 2*bits iterations, producing Quotient_o all ones and Remainder_o=A[bits-1:0]; dz_o SHALL be tied 0.

Verification
REQ-025 Reset: rst=1 for 2 cycles, then release -> all outputs 0, busy_o=0, state IDLE.
REQ-026 A=225, B=15, start_i 1 cycle -> busy_o 8 cycles, done_o pulse 8 cycles after accept, Quotient_o=15, Remainder_o=0.
REQ-027 A=200, B=7 then A=255, B=1 back-to-back -> Q=28, R=4, then Q=255, R=0; second start_i during busy_o is ignored.
REQ-028 A=100, B=0 -> with DIV0_DETECT_EN: done_o 1 cycle after accept, Q=255, R=0, dz_o=1; without: done_o after 8 cycles, Q=255, R=4, dz_o=0.
REQ-029 A=99, B=5 started, rst=1 on the 4th RUN cycle -> no done_o, outputs 0, IDLE; a fresh start gives Q=19, R=4.
REQ-030 Exhaustive sweep of A 0..255 and B 1..15 -> every result satisfies REQ-020, each logged with time, A, B, Q and R to an output text file.

Source files
------------

// File: rtl/div_4bits.sv
// Sequential restoring divider: 2*bits-wide dividend by bits-wide divisor, one quotient bit per clock.
// Optional macro DIV0_DETECT_EN short-circuits a zero divisor straight to DONE with dz_o set.
module div_4bits #(
    parameter int bits = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [2*bits-1:0]   A,
    input  logic [bits-1:0]     B,
    output logic                busy_o,
    output logic                done_o,
    output logic [2*bits-1:0]   Quotient_o,
    output logic [bits-1:0]     Remainder_o,
    output logic                dz_o,
    output logic [1:0]          dbg_state
);

    localparam int CW = $clog2(2*bits);
    localparam logic [CW-1:0] LAST = CW'(2*bits-1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t            state;
    state_t            state_next;
    logic [bits:0]     rem;
    logic [2*bits-1:0] dq;
    logic [bits-1:0]   dvs;
    logic [CW-1:0]     cnt;
    logic [bits+1:0]   shifted;
    logic              ge;
    logic [bits:0]     rem_next;
    logic [2*bits-1:0] dq_next;
    logic              accept;
    logic              div0;

    // dq starts as the dividend; its MSB feeds the remainder while quotient bits enter at the LSB.
    always_comb begin
        accept   = (state == IDLE) && start_i;
`ifdef DIV0_DETECT_EN
        div0     = (B == '0);
`else
        div0     = 1'b0;
`endif
        shifted  = {rem, dq[2*bits-1]};
        ge       = (shifted >= {2'b00, dvs});
        rem_next = ge ? (bits+1)'(shifted - {2'b00, dvs}) : shifted[bits:0];
        dq_next  = {dq[2*bits-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = div0 ? DONE : RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem         <= '0;
            dq          <= '0;
            dvs         <= '0;
            cnt         <= '0;
            Quotient_o  <= '0;
            Remainder_o <= '0;
`ifdef DIV0_DETECT_EN
            dz_o        <= 1'b0;
`endif
        end else if (accept) begin
            rem <= '0;
            dq  <= A;
            dvs <= B;
            cnt <= '0;
`ifdef DIV0_DETECT_EN
            if (div0) begin
                Quotient_o  <= '1;
                Remainder_o <= '0;
                dz_o        <= 1'b1;
            end
`endif
        end else if (state == RUN) begin
            rem <= rem_next;
            dq  <= dq_next;
            cnt <= cnt + 1'b1;
            // Outputs change only on the final iteration so no partial result is ever visible.
            if (cnt == LAST) begin
                Quotient_o  <= dq_next;
                Remainder_o <= rem_next[bits-1:0];
`ifdef DIV0_DETECT_EN
                dz_o        <= 1'b0;
`endif
            end
        end
    end

`ifndef DIV0_DETECT_EN
    assign dz_o = 1'b0;
`endif

    assign busy_o    = (state == RUN);
    assign done_o    = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_div_4bits.sv
// Directed + sweep bench for div_4bits: results are queued at start and compared when done_o pulses.
// Expectations follow the DIV0_DETECT_EN setting of the build.
module tb_div_4bits;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic [7:0] A;
    logic [3:0] B;
    logic       busy_o;
    logic       done_o;
    logic [7:0] Quotient_o;
    logic [3:0] Remainder_o;
    logic       dz_o;
    logic [1:0] dbg_state;

    int vectors;
    int miscompares;
    logic [12:0] exp_q[$];
    logic [7:0]  prev_q;
    logic [3:0]  prev_r;

    div_4bits #(.bits(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .A(A), .B(B),
        .busy_o(busy_o), .done_o(done_o), .Quotient_o(Quotient_o),
        .Remainder_o(Remainder_o), .dz_o(dz_o), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: {dz, quotient, remainder}.
    function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) begin
`ifdef DIV0_DETECT_EN
            return {1'b1, 8'hff, 4'h0};
`else
            return {1'b0, 8'hff, a[3:0]};
`endif
        end
        return {1'b0, 8'(a / b), 4'(a % b)};
    endfunction

    function automatic int lat_of(input logic [3:0] b);
`ifdef DIV0_DETECT_EN
        if (b == 4'd0) return 0;
`endif
        return 8;
    endfunction

    // Called on a negedge in IDLE; returns on the first negedge after the accepting edge.
    task automatic drive_start(input logic [7:0] a, input logic [3:0] b, input bit push);
        A       = a;
        B       = b;
        start_i = 1'b1;
        if (push) exp_q.push_back(model(a, b));
        @(negedge clk);
        start_i = 1'b0;
        A       = 8'($urandom_range(0, 255));
        B       = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_done(input int exp_lat, input int glitch_at, input bit poke_in_done);
        int   k;
        int   busy_n;
        bit   seen;
        bit   hold_ok;
        bit   overlap;
        logic [12:0] exp;
        k = 1; busy_n = 0; seen = 0; hold_ok = 1; overlap = 0;
        while (!seen && k <= 40) begin
            if (busy_o === 1'b1 && done_o === 1'b1) overlap = 1;
            if (glitch_at > 0) begin
                start_i = (k == glitch_at);
                if (k == glitch_at) begin A = 8'd3; B = 4'd2; end
            end
            if (done_o === 1'b1) seen = 1;
            else begin
                if (busy_o === 1'b1) busy_n++;
                if (Quotient_o !== prev_q || Remainder_o !== prev_r) hold_ok = 0;
                @(negedge clk);
                k++;
            end
        end
        start_i = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        if (!seen) begin
            exp_q.delete();
            return;
        end
        check("latency", 32'(k - 1), 32'(exp_lat));
        check("busy_cycles", 32'(busy_n), 32'(exp_lat));
        check("outputs_held", 32'(hold_ok), 32'd1);
        check("busy_done_overlap", 32'(overlap), 32'd0);
        exp = exp_q.pop_front();
        check("quotient", 32'(Quotient_o), 32'(exp[11:4]));
        check("remainder", 32'(Remainder_o), 32'(exp[3:0]));
        check("dz", 32'(dz_o), 32'(exp[12]));
        prev_q = exp[11:4];
        prev_r = exp[3:0];
        if (poke_in_done) begin
            start_i = 1'b1; A = 8'd9; B = 4'd3;
        end
        @(negedge clk);
        start_i = 1'b0;
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("back_to_idle", 32'(dbg_state), 32'd0);
        if (poke_in_done) begin
            @(negedge clk);
            check("start_in_done_ignored", 32'(dbg_state), 32'd0);
            check("no_busy_after_poke", 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        int done_cnt;
        vectors = 0; miscompares = 0;
        prev_q = '0; prev_r = '0;
        rst = 1'b1; start_i = 1'b0; A = '0; B = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_quotient", 32'(Quotient_o), 32'd0);
        check("rst_remainder", 32'(Remainder_o), 32'd0);
        check("rst_dz", 32'(dz_o), 32'd0);

        drive_start(8'd225, 4'd15, 1);
        wait_done(8, 0, 0);

        // Back-to-back with an ignored start during RUN, then a start in DONE that must not queue.
        drive_start(8'd200, 4'd7, 1);
        wait_done(8, 4, 0);
        drive_start(8'd255, 4'd1, 1);
        wait_done(8, 0, 1);

        drive_start(8'd100, 4'd0, 1);
        wait_done(lat_of(4'd0), 0, 0);

        // Reset on the 4th RUN cycle aborts without a done pulse.
        drive_start(8'd99, 4'd5, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", 32'(dbg_state), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_quotient", 32'(Quotient_o), 32'd0);
        check("abort_remainder", 32'(Remainder_o), 32'd0);
        check("abort_dz", 32'(dz_o), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_o === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        prev_q = '0; prev_r = '0;
        drive_start(8'd99, 4'd5, 1);
        wait_done(8, 0, 0);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra;
            logic [3:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = (i == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            drive_start(ra, rb, 1);
            wait_done(lat_of(rb), 0, 0);
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                drive_start(8'(a), 4'(b), 1);
                wait_done(8, 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
